ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
Parametrised control-signal pipeline that carries a decoded control bundle from decode through STAGES downstream stages (E, M, W, ...). It replaces the fixed-width, hand-instantiated per-stage control registers with one block. The block adds per-stage valid bits, upstream stall propagation and automatic bubble insertion. Sits in the controller between the main/ALU decoders and the datapath stage consumers.

Parameters:
WIDTH, 13, bit width of the control bundle carried per stage
STAGES, 3, number of pipeline stages after decode (stage 0 = E, 1 = M, 2 = W)
BUBBLE_ON_STALL, 1, 1: stage downstream of a stalled stage loads a bubble; 0: it reloads the stalled stage's contents (legacy flop behaviour)

Ports:
clk  in  1  pipeline clock, rising edge
rst  in  1  asynchronous, active-high reset
in_data  in  WIDTH  decode-stage control bundle
in_valid  in  1  in_data holds a real instruction
stall  in  STAGES  stall[i] requests hold of stage i
flush  in  STAGES  flush[i] clears stage i at next edge
stage_data  out  STAGES*WIDTH  stage i contents at [i*WIDTH +: WIDTH]
stage_valid  out  STAGES  stage i holds a real instruction
out_data  out  WIDTH  alias of last stage data
out_valid  out  1  alias of last stage valid
stall_up  out  1  decode must hold (effective stall of stage 0)

Behaviour:
- Reset (async, rst=1): all stage_data = 0, all stage_valid = 0, immediately, independent of clk. Outputs remain so until first rising edge after rst deasserts.
- Latency: in_data appears on stage_data[0] one cycle after capture, on out_data STAGES cycles after, when no stalls.
- Effective stall (combinational): st[STAGES-1] = stall[STAGES-1]; st[i] = stall[i] | st[i+1]. stall_up = st[0]. A stall in a later stage freezes every earlier stage in the same cycle.
- Per-stage next state, priority highest first:
  1. flush[i]=1: data <= 0, valid <= 0 (overrides stall; the stage still counts as stalled for upstream).
  2. st[i]=1: hold data and valid.
  3. Upstream stalled (i>0 and st[i-1]=1) with BUBBLE_ON_STALL=1: data <= 0, valid <= 0.
  4. Otherwise load upstream: stage 0 from in_data/in_valid; stage i from stage i-1. With BUBBLE_ON_STALL=0, rule 3 is skipped and rule 4 applies.
- Invalid masking: any load whose source valid=0 stores data=0. Invalid stages therefore never present non-zero control, so regwrite/memen are never spuriously asserted.
- Flush of stage i and stall of stage j>i in the same cycle: stage i is cleared, and stages i+1..j hold.
- All stall and flush bits set: every stage is cleared, stall_up=1.
- STAGES=1: stage 0 is both first and last; st[0]=stall[0].
- Reset asserted mid-stall or mid-flush: reset wins asynchronously, and the pipeline is empty after reset.
- No combinational path from in_data to any output; stall_up depends only on stall.

Test Plan:
- Reset: drive in_valid=1, in_data=0x1ABC and assert rst between edges -> stage_valid=000 and all data 0 without a clock edge; after release, 0x1ABC reaches out_data with out_valid=1 exactly 3 cycles later.
- Streaming: feed A=0x0001, B=0x0002, C=0x0003 on consecutive cycles, no stalls -> out_data sequence A,B,C on cycles 3,4,5, with out_valid=1 each.
- Stall propagation: stage 1 holding B, stall=3'b010 for 2 cycles -> stall_up=1, stage 0 and stage 1 hold, stage 2 shows bubble (valid 0, data 0) for 2 cycles, then B exits; rerun with BUBBLE_ON_STALL=0 -> stage 2 shows B for 3 consecutive cycles.
- Flush vs stall: stall=3'b001 and flush=3'b001 in the same cycle with stage 0 = 0x1FFF -> stage 0 becomes 0/invalid, stage 1 gets a bubble, stall_up=1.
- Invalid masking: in_valid=0 with in_data=0x1FFF -> stage_data[0]=0, stage_valid[0]=0; out_data never non-zero.
- Parametrisation: WIDTH=8, STAGES=1 and WIDTH=20, STAGES=5 -> latency equals STAGES; a stall in the last stage freezes all stages.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries the decoded control bundle from decode through STAGES
// downstream stages. Each stage has a valid bit. Stalls propagate upstream,
// and bubbles are inserted automatically. A stage that holds no real
// instruction always presents an all-zero bundle, so downstream enables
// such as regwrite and memen stay low.
module ctrl_pipe #(
  parameter int WIDTH           = 13,
  parameter int STAGES          = 3,
  parameter bit BUBBLE_ON_STALL = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  input  logic [STAGES-1:0]         stall,
  input  logic [STAGES-1:0]         flush,
  output logic [STAGES*WIDTH-1:0]   stage_data,
  output logic [STAGES-1:0]         stage_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_valid,
  output logic                      stall_up
);

  typedef logic [WIDTH-1:0] bundleT;

  // Action each stage takes at the next edge. A "hold" keeps the
  // current contents.
  typedef enum logic [1:0] {
    ACT_LOAD  = 2'd0,
    ACT_HOLD  = 2'd1,
    ACT_CLEAR = 2'd2
  } stageActT;

  bundleT            dataReg   [STAGES];
  logic [STAGES-1:0] validReg;

  bundleT            nextData  [STAGES];
  logic [STAGES-1:0] nextValid;

  bundleT            srcData   [STAGES];
  logic [STAGES-1:0] srcValid;
  logic [STAGES-1:0] upStalled;
  logic [STAGES-1:0] effStall;
  stageActT          stageAct  [STAGES];

  // Effective stall: a stage is frozen when it stalls itself or when any
  // later stage stalls. This depends only on the stall inputs.
  always_comb begin
    effStall = '0;
    for (int i = 0; i < STAGES; i++) begin
      effStall[i] = |(stall >> i);
    end
  end

  // Wire each stage to its upstream source.
  // Stage 0 is fed from decode, and later stages are fed from their
  // predecessor.
  for (genvar g = 0; g < STAGES; g++) begin : gStage
    if (g == 0) begin : gFirst
      assign srcData[g]   = in_data;
      assign srcValid[g]  = in_valid;
      assign upStalled[g] = 1'b0;
    end else begin : gRest
      assign srcData[g]   = dataReg[g-1];
      assign srcValid[g]  = validReg[g-1];
      assign upStalled[g] = effStall[g-1];
    end
    assign stage_data[g*WIDTH +: WIDTH] = dataReg[g];
  end

  // Pick each stage's action.
  // Priority is: flush, then own or downstream stall, then bubble
  // behind a stalled upstream, then load.
  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    stageAct = '{default: ACT_LOAD};
    for (int i = 0; i < STAGES; i++) begin
      if (flush[i]) begin
        stageAct[i] = ACT_CLEAR;
      end else if (effStall[i]) begin
        stageAct[i] = ACT_HOLD;
      end else if (BUBBLE_ON_STALL && upStalled[i]) begin
        stageAct[i] = ACT_CLEAR;
      end else begin
        stageAct[i] = ACT_LOAD;
      end
    end
  end

  // Apply the chosen action.
  // A load whose source is invalid stores zero data, so an invalid stage
  // never carries stale control.
  always_comb begin
    nextData  = dataReg;
    nextValid = validReg;
    for (int i = 0; i < STAGES; i++) begin
      case (stageAct[i])
        ACT_LOAD: begin
          nextValid[i] = srcValid[i];
          nextData[i]  = srcValid[i] ? srcData[i] : '0;
        end
        ACT_CLEAR: begin
          nextValid[i] = 1'b0;
          nextData[i]  = '0;
        end
        default: ;
      endcase
    end
  end

  // Stage registers. Reset empties the pipeline asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: these are a handful of control flops rather than a RAM, so every
    // entry is reset. An empty pipeline must present zero control right away.
    if (rst) begin
      dataReg  <= '{default: '0};
      validReg <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments, so every stage
      // samples its predecessor's pre-edge value.
      dataReg  <= nextData;
      validReg <= nextValid;
    end
  end

  assign stage_valid = validReg;
  assign out_data    = dataReg[STAGES-1];
  assign out_valid   = validReg[STAGES-1];
  assign stall_up    = effStall[0];

endmodule

// File: tb/tb_ctrl_pipe.sv
// Testbench for ctrl_pipe.
// The main instance streams directed vectors; the expected exit order is
// queued and a monitor pops the queue on every new output. Stage-level
// behaviour, the legacy no-bubble variant and two other parameter sets are
// checked directly.
module tb_ctrl_pipe;

  localparam int W = 13;
  localparam int S = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Shared stimulus for the default and legacy instances.
  logic [W-1:0]   inData;
  logic           inValid;
  logic [S-1:0]   stall;
  logic [S-1:0]   flush;

  logic [S*W-1:0] stageData0, stageDataL;
  logic [S-1:0]   stageValid0, stageValidL;
  logic [W-1:0]   outData0, outDataL;
  logic           outValid0, outValidL, stallUp0, stallUpL;

  // Instance with WIDTH=8, STAGES=1.
  logic [7:0] p1Data, p1StageData, p1OutData;
  logic       p1Valid, p1Stall, p1Flush, p1StageValid, p1OutValid, p1StallUp;

  // Instance with WIDTH=20, STAGES=5.
  logic [19:0]  p5Data, p5OutData;
  logic [99:0]  p5StageData;
  logic [4:0]   p5Stall, p5Flush, p5StageValid;
  logic         p5Valid, p5OutValid, p5StallUp;

  ctrl_pipe #(.WIDTH(W), .STAGES(S), .BUBBLE_ON_STALL(1'b1)) dut (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .stall(stall), .flush(flush), .stage_data(stageData0),
    .stage_valid(stageValid0), .out_data(outData0), .out_valid(outValid0),
    .stall_up(stallUp0));

  ctrl_pipe #(.WIDTH(W), .STAGES(S), .BUBBLE_ON_STALL(1'b0)) dutLegacy (
    .clk(clk), .rst(rst), .in_data(inData), .in_valid(inValid),
    .stall(stall), .flush(flush), .stage_data(stageDataL),
    .stage_valid(stageValidL), .out_data(outDataL), .out_valid(outValidL),
    .stall_up(stallUpL));

  ctrl_pipe #(.WIDTH(8), .STAGES(1), .BUBBLE_ON_STALL(1'b1)) dutS1 (
    .clk(clk), .rst(rst), .in_data(p1Data), .in_valid(p1Valid),
    .stall(p1Stall), .flush(p1Flush), .stage_data(p1StageData),
    .stage_valid(p1StageValid), .out_data(p1OutData), .out_valid(p1OutValid),
    .stall_up(p1StallUp));

  ctrl_pipe #(.WIDTH(20), .STAGES(5), .BUBBLE_ON_STALL(1'b1)) dutS5 (
    .clk(clk), .rst(rst), .in_data(p5Data), .in_valid(p5Valid),
    .stall(p5Stall), .flush(p5Flush), .stage_data(p5StageData),
    .stage_valid(p5StageValid), .out_data(p5OutData), .out_valid(p5OutValid),
    .stall_up(p5StallUp));

  int total = 0;
  int bad   = 0;

  logic [W-1:0] sb[$];
  logic         held2;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input logic [W-1:0] d, input logic v, input logic expectExit);
    inData  = d;
    inValid = v;
    if (expectExit) sb.push_back(d);
  endtask

  // Track whether the last stage was held at the latest edge. A held output
  // is the same instruction as before and must not be consumed twice.
  always @(posedge clk or posedge rst) begin
    if (rst) held2 <= 1'b0;
    else     held2 <= stall[S-1] & ~flush[S-1];
  end

  // Monitor: compare each new output against the scoreboard. Idle cycles
  // must present zero control.
  always @(negedge clk) begin
    if (!rst) begin
      if (outValid0) begin
        if (!held2) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got %0h expected no output", outData0);
          end else begin
            check("sb_out", outData0, sb.pop_front());
          end
        end
      end else begin
        check("idle_zero", outData0, 0);
      end
    end
  end

  logic [99:0] exp5;
  int          lat1, lat5;

  initial begin
    rst = 1'b1; inData = '0; inValid = 1'b0; stall = '0; flush = '0;
    p1Data = '0; p1Valid = 1'b0; p1Stall = 1'b0; p1Flush = 1'b0;
    p5Data = '0; p5Valid = 1'b0; p5Stall = '0; p5Flush = '0;
    repeat (2) @(negedge clk);
    check("reset_valid", stageValid0, 0);
    check("reset_data", stageData0, 0);

    // Reset: fill two stages, then reset between edges.
    rst = 1'b0;
    send(13'h0AAA, 1'b1, 1'b0); tick();
    send(13'h0BBB, 1'b1, 1'b0); tick();
    check("prefill_valid", stageValid0, 3'b011);
    inData = 13'h1ABC; inValid = 1'b1; rst = 1'b1;
    #1;
    check("async_rst_valid", stageValid0, 0);
    check("async_rst_data", stageData0, 0);
    tick();
    check("rst_held_valid", stageValid0, 0);
    rst = 1'b0;
    send(13'h1ABC, 1'b1, 1'b1); tick();
    check("lat_s0_valid", stageValid0, 3'b001);
    check("lat_s0_data", stageData0[W-1:0], 13'h1ABC);
    send(0, 1'b0, 1'b0); tick();
    check("lat_c2_outvalid", outValid0, 1'b0);
    tick();
    check("lat_c3_outvalid", outValid0, 1'b1);
    check("lat_c3_outdata", outData0, 13'h1ABC);
    tick();

    // Streaming A, B, C back to back.
    send(13'h0001, 1'b1, 1'b1); tick();
    send(13'h0002, 1'b1, 1'b1); tick();
    send(13'h0003, 1'b1, 1'b1); tick();
    send(0, 1'b0, 1'b0);
    check("stream_a", outData0, 13'h0001);
    tick();
    check("stream_b", outData0, 13'h0002);
    tick();
    check("stream_c", outData0, 13'h0003);
    check("stream_c_valid", outValid0, 1'b1);
    tick();
    check("stream_drained", outValid0, 1'b0);

    // Stall propagation: stage 1 holds B for two cycles.
    send(13'h00A1, 1'b1, 1'b1); tick();
    send(13'h00B2, 1'b1, 1'b1); tick();
    send(13'h00C3, 1'b1, 1'b1); tick();
    send(0, 1'b0, 1'b0);
    stall = 3'b010;
    #1;
    check("stall_up_mid", stallUp0, 1'b1);
    check("stall_up_legacy", stallUpL, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("stall_valid", stageValid0, 3'b011);
      check("stall_s0", stageData0[0 +: W], 13'h00C3);
      check("stall_s1", stageData0[W +: W], 13'h00B2);
      check("stall_bubble", stageData0[2*W +: W], 0);
      check("legacy_valid", stageValidL, 3'b111);
      check("legacy_s2", stageDataL[2*W +: W], 13'h00B2);
    end
    stall = 3'b000;
    tick();
    check("stall_exit_b", outData0, 13'h00B2);
    check("legacy_third_b", outDataL, 13'h00B2);
    check("legacy_third_valid", outValidL, 1'b1);
    tick();
    check("stall_exit_c", outData0, 13'h00C3);
    tick();

    // Flush and stall on stage 0 together.
    send(13'h0123, 1'b1, 1'b1); tick();
    send(13'h1FFF, 1'b1, 1'b0); tick();
    check("fs_setup_s0", stageData0[0 +: W], 13'h1FFF);
    send(0, 1'b0, 1'b0);
    stall = 3'b001; flush = 3'b001;
    #1;
    check("fs_stall_up", stallUp0, 1'b1);
    tick();
    check("fs_valid", stageValid0, 3'b100);
    check("fs_s0_s1", stageData0[2*W-1:0], 0);
    check("fs_s2", stageData0[2*W +: W], 13'h0123);
    stall = '0; flush = '0;
    tick();

    // Flush stage 0 while stage 2 stalls.
    send(13'h0111, 1'b1, 1'b1); tick();
    send(13'h0222, 1'b1, 1'b1); tick();
    send(13'h0333, 1'b1, 1'b0); tick();
    send(0, 1'b0, 1'b0);
    stall = 3'b100; flush = 3'b001;
    #1;
    check("fl_stall_up", stallUp0, 1'b1);
    tick();
    check("fl_valid", stageValid0, 3'b110);
    check("fl_s0", stageData0[0 +: W], 0);
    check("fl_s1", stageData0[W +: W], 13'h0222);
    check("fl_s2", stageData0[2*W +: W], 13'h0111);
    stall = '0; flush = '0;
    tick();
    check("fl_exit_q", outData0, 13'h0222);
    tick();
    check("fl_drained", outValid0, 1'b0);

    // Every stall and flush bit set at once.
    send(13'h0444, 1'b1, 1'b0); tick();
    send(13'h0555, 1'b1, 1'b0); tick();
    send(0, 1'b0, 1'b0);
    stall = 3'b111; flush = 3'b111;
    #1;
    check("all_stall_up", stallUp0, 1'b1);
    tick();
    check("all_valid", stageValid0, 0);
    check("all_data", stageData0, 0);
    stall = '0; flush = '0;
    #1;
    check("stall_up_clear", stallUp0, 1'b0);

    // Invalid masking: an invalid instruction with non-zero data.
    send(13'h1FFF, 1'b0, 1'b0); tick();
    check("mask_s0_valid", stageValid0[0], 1'b0);
    check("mask_s0_data", stageData0[0 +: W], 0);
    send(0, 1'b0, 1'b0);
    repeat (3) tick();

    // Parametrisation: the latency equals STAGES.
    p1Data = 8'hA5; p1Valid = 1'b1;
    p5Data = 20'hABCDE; p5Valid = 1'b1;
    tick();
    p1Valid = 1'b0; p1Data = '0; p5Valid = 1'b0; p5Data = '0;
    lat1 = 0; lat5 = 0;
    for (int c = 1; c <= 10; c++) begin
      if (p1OutValid && lat1 == 0) begin
        lat1 = c;
        check("p1_data", p1OutData, 8'hA5);
      end
      if (p5OutValid && lat5 == 0) begin
        lat5 = c;
        check("p5_data", p5OutData, 20'hABCDE);
      end
      tick();
    end
    check("p1_latency", lat1, 1);
    check("p5_latency", lat5, 5);

    // Last-stage stall freezes every stage.
    for (int k = 0; k < 5; k++) begin
      p5Data = 20'h10000 + 20'(k); p5Valid = 1'b1;
      if (k == 4) begin
        p1Data = 8'h3C; p1Valid = 1'b1;
      end
      tick();
    end
    p5Valid = 1'b0; p5Data = '0; p1Valid = 1'b0; p1Data = '0;
    p5Stall = 5'b10000; p1Stall = 1'b1;
    for (int i = 0; i < 5; i++) exp5[i*20 +: 20] = 20'h10000 + 20'(4 - i);
    #1;
    check("p5_stall_up", p5StallUp, 1'b1);
    check("p1_stall_up", p1StallUp, 1'b1);
    for (int k = 0; k < 2; k++) begin
      tick();
      check("p5_freeze_data", p5StageData, exp5);
      check("p5_freeze_valid", p5StageValid, 5'b11111);
      check("p1_freeze_data", p1StageData, 8'h3C);
      check("p1_freeze_valid", p1StageValid, 1'b1);
    end
    p5Stall = '0; p1Stall = 1'b0;
    tick();
    check("p1_released", p1OutValid, 1'b0);
    check("p5_released_out", p5OutData, 20'h10001);

    repeat (2) tick();
    check("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
